// File: rtl/mem_arbiter_if.sv
// Request, memory-port and status signals shared by the arbiter and its environment.
// master is the arbiter side, slave is the requester/memory side.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        err;
    logic        stall;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ready, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, m_be, err, stall
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ready, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, m_be, err, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single registered memory port,
// with fetch anti-starvation and a per-transaction wait timeout.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.master bus,
    output logic [1:0]   o_dbg_state
);
    // Handshake: a requester holds x_req and its command until x_ack; the memory
    // completes the command in the cycle it drives m_ready=1 while m_req=1.
    typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

    localparam logic [3:0] LP_STARVE   = 4'(STARVE_MAX);
    localparam logic [7:0] LP_WAIT_END = 8'(TIMEOUT - 1);

    state_t      r_state, w_next_state;
    logic        r_m_req, r_m_we;
    logic [31:0] r_m_addr, r_m_wdata;
    logic [3:0]  r_m_be;
    logic        r_i_ack, r_d_ack, r_err;
    logic [31:0] r_i_rdata, r_d_rdata;
    logic [3:0]  r_starve;
    logic [7:0]  r_wait;
    logic        w_fetch_wins, w_grant_i, w_grant_d, w_done, w_timeout;

    always_comb begin
        w_next_state = r_state;
        w_fetch_wins = 1'b0;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                // Priority is decided on raw requests; a winner still seeing its own ack
                // is a stale request, so nobody is granted that cycle.
                w_fetch_wins = bus.i_req & (~bus.d_req | (r_starve == LP_STARVE));
                w_grant_i    = w_fetch_wins & ~r_i_ack;
                w_grant_d    = ~w_fetch_wins & bus.d_req & ~r_d_ack;
                if (w_grant_i)      w_next_state = GNT_I;
                else if (w_grant_d) w_next_state = GNT_D;
            end
            GNT_I, GNT_D: begin
                if (bus.m_ready)                w_done    = 1'b1;
                else if (r_wait == LP_WAIT_END) w_timeout = 1'b1;
                if (w_done | w_timeout) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= 32'h0;
            r_m_wdata <= 32'h0;
            r_m_be    <= 4'h0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_err     <= 1'b0;
            r_i_rdata <= 32'h0;
            r_d_rdata <= 32'h0;
            r_starve  <= 4'h0;
            r_wait    <= 8'h0;
        end else begin
            r_state <= w_next_state;
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_err   <= 1'b0;
            if (w_grant_i) begin
                r_m_req   <= 1'b1;
                r_m_we    <= 1'b0;
                r_m_addr  <= bus.i_addr & 32'hFFFF_FFFC;
                r_m_wdata <= 32'h0;
                r_m_be    <= 4'hF;
                r_wait    <= 8'h0;
                r_starve  <= 4'h0;
            end else if (w_grant_d) begin
                r_m_req   <= 1'b1;
                r_m_we    <= bus.d_we;
                r_m_addr  <= bus.d_addr;
                r_m_wdata <= bus.d_wdata;
                r_m_be    <= bus.d_we ? bus.d_be : 4'hF;
                r_wait    <= 8'h0;
                if (!bus.i_req)                r_starve <= 4'h0;
                else if (r_starve != LP_STARVE) r_starve <= r_starve + 4'd1;
            end
            if (w_done | w_timeout) begin
                r_m_req <= 1'b0;
                r_err   <= w_timeout;
                if (r_state == GNT_I) begin
                    r_i_ack   <= 1'b1;
                    r_i_rdata <= w_done ? bus.m_rdata : 32'h0;
                end else begin
                    r_d_ack <= 1'b1;
                    if (w_timeout)    r_d_rdata <= 32'h0;
                    else if (!r_m_we) r_d_rdata <= bus.m_rdata;
                end
            end else if (r_state != IDLE) begin
                r_wait <= r_wait + 8'd1;
            end
        end
    end

    assign bus.m_req    = r_m_req;
    assign bus.m_we     = r_m_we;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_wdata  = r_m_wdata;
    assign bus.m_be     = r_m_be;
    assign bus.i_ack    = r_i_ack;
    assign bus.d_ack    = r_d_ack;
    assign bus.err      = r_err;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.stall    = (bus.i_req & ~r_i_ack) | (bus.d_req & ~r_d_ack);
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter with STARVE_MAX=4, TIMEOUT=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;
  logic clk;
  logic reset;
  logic [1:0] dbg_state;
  int n_tests;
  int n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] grant_q[$];
  logic [31:0] got;
  logic [31:0] rd;
  bit ok;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_mreq(output bit found);
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (bus.m_req) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) check("wait_mreq", 32'(bus.m_req), 32'd1);
  endtask

  task automatic serve(input int delay, input logic [31:0] rdata);
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0] b;
    a = bus.m_addr;
    w = bus.m_wdata;
    b = bus.m_be;
    for (int k = 0; k < delay; k++) begin
      tick();
      check("hold_addr", bus.m_addr, a);
      check("hold_wdata", bus.m_wdata, w);
      check("hold_be", 32'(bus.m_be), 32'(b));
      check("hold_stall", 32'(bus.stall), 32'd1);
    end
    bus.m_ready = 1'b1;
    bus.m_rdata = rdata;
    tick();
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'h0;
  endtask

  task automatic start_load(input logic [31:0] addr);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = addr;
    bus.d_be   = 4'h0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0;
    bus.d_wdata = 32'h0; bus.d_be = 4'h0;
    bus.m_ready = 1'b0; bus.m_rdata = 32'h0;
    repeat (3) tick();

    // reset state
    check("rst_m_req", 32'(bus.m_req), 32'd0);
    check("rst_m_addr", bus.m_addr, 32'h0);
    check("rst_m_be", 32'(bus.m_be), 32'h0);
    check("rst_acks", 32'({bus.i_ack, bus.d_ack, bus.err}), 32'd0);
    check("rst_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    tick();

    // m_ready in IDLE is ignored
    bus.m_ready = 1'b1; bus.m_rdata = 32'h5555_5555;
    tick();
    bus.m_ready = 1'b0;
    check("idle_ready_acks", 32'({bus.i_ack, bus.d_ack, bus.err}), 32'd0);
    check("idle_ready_rdata", bus.i_rdata | bus.d_rdata, 32'h0);

    // single fetch with minimum latency
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0013;
    exp_q.push_back(32'h2402_0005);
    tick();
    check("f_m_req", 32'(bus.m_req), 32'd1);
    check("f_m_addr", bus.m_addr, 32'h0000_0010);
    check("f_m_we_be", 32'({bus.m_we, bus.m_be}), 32'h0F);
    check("f_m_wdata", bus.m_wdata, 32'h0);
    check("f_stall", 32'(bus.stall), 32'd1);
    serve(0, 32'h2402_0005);
    check("f_i_ack", 32'(bus.i_ack), 32'd1);
    check("f_i_rdata", bus.i_rdata, exp_q.pop_front());
    check("f_err", 32'(bus.err), 32'd0);
    check("f_m_req_low", 32'(bus.m_req), 32'd0);
    bus.i_req = 1'b0;
    tick();
    check("f_ack_pulse", 32'(bus.i_ack), 32'd0);
    check("f_rdata_held", bus.i_rdata, 32'h2402_0005);

    // simultaneous requests: store first, then fetch
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0040;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'b0011;
    tick();
    check("sim_d_addr", bus.m_addr, 32'h100);
    check("sim_d_we_be", 32'({bus.m_we, bus.m_be}), 32'h13);
    check("sim_d_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    serve(0, 32'h7777_7777);
    check("sim_d_ack", 32'({bus.d_ack, bus.i_ack}), 32'h2);
    check("sim_store_no_rdata", bus.d_rdata, 32'h0);
    bus.d_req = 1'b0;
    tick();
    check("sim_f_grant", 32'({bus.m_req, bus.m_we}), 32'h2);
    check("sim_f_addr", bus.m_addr, 32'h40);
    serve(0, 32'h1111_2222);
    check("sim_i_ack", 32'(bus.i_ack), 32'd1);
    check("sim_i_rdata", bus.i_rdata, 32'h1111_2222);
    bus.i_req = 1'b0;
    tick();

    // back-to-back load: the request still high during d_ack is not re-granted
    start_load(32'h180);
    bus.d_be = 4'h5;
    tick();
    check("b2b_load_be", 32'(bus.m_be), 32'hF);
    serve(0, 32'hA5A5_0001);
    check("b2b_d_rdata", bus.d_rdata, 32'hA5A5_0001);
    bus.d_addr = 32'h184;
    tick();
    check("b2b_no_stale", 32'(bus.m_req), 32'd0);
    tick();
    check("b2b_regrant", 32'(bus.m_req), 32'd1);
    check("b2b_addr", bus.m_addr, 32'h184);
    serve(1, 32'hA5A5_0002);
    check("b2b_d_rdata2", bus.d_rdata, 32'hA5A5_0002);
    bus.d_req = 1'b0;
    tick();

    // starvation: four data grants, one fetch, then data again
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    start_load(32'h300);
    grant_q = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h200, 32'h300};
    for (int g = 0; g < 6; g++) begin
      wait_mreq(ok);
      if (!ok) break;
      got = bus.m_addr;
      check("starve_order", got, grant_q.pop_front());
      rd = $urandom;
      exp_q.push_back(rd);
      serve(0, rd);
      if (got == 32'h200) begin
        check("starve_i_ack", 32'(bus.i_ack), 32'd1);
        check("starve_i_rdata", bus.i_rdata, exp_q.pop_front());
        bus.i_req = 1'b0;
      end else begin
        check("starve_d_ack", 32'(bus.d_ack), 32'd1);
        check("starve_d_rdata", bus.d_rdata, exp_q.pop_front());
      end
      if (g == 5) bus.d_req = 1'b0;
    end
    tick();

    // timeout: no m_ready for 8 cycles
    start_load(32'h400);
    tick();
    check("to_grant", 32'(bus.m_req), 32'd1);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("to_no_ack_early", 32'(bus.d_ack), 32'd0);
    end
    tick();
    check("to_ack_err", 32'({bus.d_ack, bus.err}), 32'h3);
    check("to_rdata_zero", bus.d_rdata, 32'h0);
    check("to_m_req_low", 32'(bus.m_req), 32'd0);
    bus.d_req = 1'b0;
    tick();
    check("to_err_pulse", 32'(bus.err), 32'd0);

    // m_ready exactly at the timeout cycle completes normally
    start_load(32'h500);
    tick();
    repeat (7) tick();
    bus.m_ready = 1'b1; bus.m_rdata = 32'hCAFE_0001;
    tick();
    bus.m_ready = 1'b0;
    check("to_edge_ack", 32'({bus.d_ack, bus.err}), 32'h2);
    check("to_edge_rdata", bus.d_rdata, 32'hCAFE_0001);
    bus.d_req = 1'b0;
    tick();

    // wait states: command stable and stall high
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h600;
    bus.d_wdata = 32'h1234_5678; bus.d_be = 4'hC;
    tick();
    check("ws_be", 32'(bus.m_be), 32'hC);
    serve(5, 32'h0);
    check("ws_ack", 32'({bus.d_ack, bus.err}), 32'h2);
    bus.d_req = 1'b0;
    tick();

    // reset two cycles into a fetch grant
    bus.i_req = 1'b1; bus.i_addr = 32'h700;
    tick();
    check("rg_grant", 32'(dbg_state), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rg_async_m_req", 32'(bus.m_req), 32'd0);
    check("rg_async_state", 32'(dbg_state), 32'd0);
    bus.i_req = 1'b0;
    start_load(32'h800);
    tick();
    check("rg_no_ack", 32'({bus.i_ack, bus.d_ack}), 32'd0);
    reset = 1'b1;
    tick();
    check("rg_d_grant", 32'(bus.m_req), 32'd1);
    check("rg_d_addr", bus.m_addr, 32'h800);
    serve(0, 32'h0BAD_F00D);
    check("rg_d_rdata", bus.d_rdata, 32'h0BAD_F00D);
    bus.d_req = 1'b0;
    tick();

    // random loads with random wait states
    for (int r = 0; r < 4; r++) begin
      start_load({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      bus.d_be = 4'($urandom_range(0, 15));
      got = bus.d_addr;
      wait_mreq(ok);
      if (!ok) break;
      check("rnd_addr", bus.m_addr, got);
      check("rnd_be", 32'(bus.m_be), 32'hF);
      rd = $urandom;
      exp_q.push_back(rd);
      serve(int'($urandom_range(0, 4)), rd);
      check("rnd_ack", 32'({bus.d_ack, bus.err}), 32'h2);
      check("rnd_rdata", bus.d_rdata, exp_q.pop_front());
      bus.d_req = 1'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
